// File: rtl/ce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ce_pkg
//  Description : Shared constants, error codes, frame-builder state encoding
//                and the frame-length legality helper for the CE framer.
//  Revision    : 1.0  initial release
// ============================================================================
package ce_pkg;

    localparam int FFTPTS_W   = 12;
    localparam int FFTPTS_MIN = 64;
    localparam int FFTPTS_MAX = 2048;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_LEN = 2'b01;

    // Frame-builder states; GAP is only reachable when the gap feature is built in
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Only the FFT sizes the CE chain supports are accepted
    function automatic logic len_is_legal(input logic [FFTPTS_W-1:0] len);
        logic ok;
        case (len)
            12'd64, 12'd128, 12'd256, 12'd512, 12'd1024, 12'd2048: ok = 1'b1;
            default:                                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ce_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : ce_skid_buf
//  Description : Two-entry valid/ready skid buffer. The head entry drives the
//                output directly, so a beat pushed into an empty buffer is
//                visible right after the accepting edge. Ready is registered.
//  Revision    : 1.0  initial release
// ============================================================================
module ce_skid_buf #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [WIDTH-1:0] o_m_data
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_ready;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_nxt;

    assign w_push      = i_s_valid && r_ready;
    assign w_pop       = (r_count != 2'd0) && i_m_ready;
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    // Storage, pointers and occupancy; ready looks ahead at next occupancy
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_mem[0] <= RST_VAL;
            r_mem[1] <= RST_VAL;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_s_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != 2'd2);
        end
    end

    assign o_s_ready = r_ready;
    assign o_m_valid = (r_count != 2'd0);
    assign o_m_data  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/ce_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ce_frame_tx
//  Description : Transmit framer feeding the CE chain. Cuts an unframed
//                complex sample stream into frames of fftpts_in samples,
//                tags sop/eop/error/length and buffers through a skid buffer.
//                Optional macro CE_FRAME_GAP_EN inserts one input-idle cycle
//                after each frame.
//  Revision    : 1.0  initial release
// ============================================================================
module ce_frame_tx
    import ce_pkg::*;
#(
    parameter int wData = 16,
    parameter int wCnt  = 16
) (
    input  logic                clk,
    input  logic                rst_async,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [wData-1:0]    in_real,
    input  logic [wData-1:0]    in_imag,
    input  logic [FFTPTS_W-1:0] fftpts_in,
    output logic                source_valid,
    input  logic                source_ready,
    output logic [1:0]          source_error,
    output logic                source_sop,
    output logic                source_eop,
    output logic [wData-1:0]    source_real,
    output logic [wData-1:0]    source_imag,
    output logic [FFTPTS_W-1:0] fftpts_out,
    output logic [wCnt-1:0]     frame_cnt
);

    // Beat layout: {real, imag, sop, eop, error[1:0], len}
    localparam int                  c_BEAT_W   = 2 * wData + 4 + FFTPTS_W;
    localparam logic [c_BEAT_W-1:0] c_BEAT_RST = c_BEAT_W'(FFTPTS_MIN);

    state_t              r_state;
    logic [FFTPTS_W-1:0] r_len;
    logic [FFTPTS_W-1:0] r_idx;
    logic [1:0]          r_err;
    logic [wCnt-1:0]     r_frame_cnt;

    state_t              w_state_nxt;
    logic [FFTPTS_W-1:0] w_len_nxt;
    logic [FFTPTS_W-1:0] w_idx_nxt;
    logic [1:0]          w_err_nxt;
    logic                w_len_legal;
    logic                w_beat_sop;
    logic                w_beat_eop;
    logic [1:0]          w_beat_err;
    logic [FFTPTS_W-1:0] w_beat_len;

    logic                w_skid_ready;
    logic                w_acc;
    logic                w_m_valid;
    logic [c_BEAT_W-1:0] w_m_data;

`ifdef CE_FRAME_GAP_EN
    assign in_ready = w_skid_ready && (r_state != GAP);
`else
    assign in_ready = w_skid_ready;
`endif

    assign w_acc = in_valid && in_ready;

    // Frame-builder state register
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_state <= IDLE;
            r_len   <= FFTPTS_W'(FFTPTS_MIN);
            r_idx   <= '0;
            r_err   <= ERR_OK;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_idx   <= w_idx_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state logic and per-beat tag generation
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_idx_nxt   = r_idx;
        w_err_nxt   = r_err;
        w_beat_sop  = 1'b0;
        w_beat_eop  = 1'b0;
        w_beat_err  = r_err;
        w_beat_len  = r_len;
        w_len_legal = len_is_legal(fftpts_in);
        case (r_state)
            IDLE: begin
                // Length is only sampled here, so mid-frame changes are ignored
                w_beat_sop = 1'b1;
                w_beat_len = w_len_legal ? fftpts_in : FFTPTS_W'(FFTPTS_MIN);
                w_beat_err = w_len_legal ? ERR_OK : ERR_LEN;
                if (w_acc) begin
                    w_len_nxt   = w_beat_len;
                    w_err_nxt   = w_beat_err;
                    w_idx_nxt   = 12'd1;
                    w_state_nxt = FRAME;
                end
            end
            FRAME: begin
                w_beat_eop = (r_idx == r_len - 12'd1);
                if (w_acc) begin
                    if (w_beat_eop) begin
                        w_idx_nxt = '0;
`ifdef CE_FRAME_GAP_EN
                        w_state_nxt = GAP;
`else
                        w_state_nxt = IDLE;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 12'd1;
                    end
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    ce_skid_buf #(
        .WIDTH   (c_BEAT_W),
        .RST_VAL (c_BEAT_RST)
    ) u_skid (
        .clk       (clk),
        .rst_async (rst_async),
        .i_s_valid (w_acc),
        .o_s_ready (w_skid_ready),
        .i_s_data  ({in_real, in_imag, w_beat_sop, w_beat_eop, w_beat_err, w_beat_len}),
        .o_m_valid (w_m_valid),
        .i_m_ready (source_ready),
        .o_m_data  (w_m_data)
    );

    assign source_valid = w_m_valid;
    assign {source_real, source_imag, source_sop, source_eop, source_error, fftpts_out} = w_m_data;

    // Completed-frame counter, advanced on each output eop handshake
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_frame_cnt <= '0;
        end else if (w_m_valid && source_ready && source_eop) begin
            r_frame_cnt <= r_frame_cnt + wCnt'(1);
        end
    end

    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ce_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ce_frame_tx
//  Description : Self-checking bench for ce_frame_tx. A queue-based model
//                derives every expected output beat from the accepted inputs;
//                literal checks pin reset values, latency and frame counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ce_frame_tx;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        sop;
        logic        eop;
        logic [1:0]  err;
        logic [11:0] len;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_async;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_real;
    logic [15:0] in_imag;
    logic [11:0] fftpts_in;
    logic        source_valid;
    logic        source_ready;
    logic [1:0]  source_error;
    logic        source_sop;
    logic        source_eop;
    logic [15:0] source_real;
    logic [15:0] source_imag;
    logic [11:0] fftpts_out;
    logic [15:0] frame_cnt;

    int    checks = 0;
    int    errors = 0;
    beat_t q[$];
    int    pos;
    logic [11:0] cur_len;
    logic [1:0]  cur_err;
    logic        legal;
    logic [15:0] m_cnt;
    logic        stall_prev;
    beat_t       stall_beat;
    beat_t       act;
    beat_t       exp_b;
    int    err_beats;
    int    drops;
    logic  mon_drops = 1'b0;
    logic  rdy_rand  = 1'b0;
    logic [15:0] last_re;

    always #5 clk = ~clk;

    ce_frame_tx #(.wData(16), .wCnt(16)) dut (
        .clk          (clk),
        .rst_async    (rst_async),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_real      (in_real),
        .in_imag      (in_imag),
        .fftpts_in    (fftpts_in),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_error (source_error),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_real  (source_real),
        .source_imag  (source_imag),
        .fftpts_out   (fftpts_out),
        .frame_cnt    (frame_cnt)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Downstream ready: always 1, or a 50% random pattern
    initial begin
        source_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            source_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Reference model and compare process
    always @(negedge clk) begin
        if (rst_async) begin
            q.delete();
            pos        = 0;
            m_cnt      = '0;
            stall_prev = 1'b0;
        end else begin
            act = {source_real, source_imag, source_sop, source_eop, source_error, fftpts_out};
            chk("valid_vs_model", 64'(source_valid), 64'(q.size() != 0));
            chk("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
            if (source_valid && stall_prev)
                chk("stall_stable", 64'(act), 64'(stall_beat));
            if (source_valid && source_ready && q.size() != 0) begin
                exp_b = q.pop_front();
                chk("out_beat", 64'(act), 64'(exp_b));
                if (exp_b.eop) m_cnt = m_cnt + 16'd1;
                if (source_error != 2'b00) err_beats++;
            end
            stall_prev = source_valid && !source_ready;
            stall_beat = act;
            if (mon_drops && in_valid && !in_ready) drops++;
            if (in_valid && in_ready) begin
                if (pos == 0) begin
                    legal   = (fftpts_in >= 12'd64) && (fftpts_in <= 12'd2048) &&
                              ((fftpts_in & (fftpts_in - 12'd1)) == 12'd0);
                    cur_len = legal ? fftpts_in : 12'd64;
                    cur_err = legal ? 2'b00 : 2'b01;
                end
                exp_b.re  = in_real;
                exp_b.im  = in_imag;
                exp_b.sop = (pos == 0);
                exp_b.eop = (pos == int'(cur_len) - 1);
                exp_b.err = cur_err;
                exp_b.len = cur_len;
                q.push_back(exp_b);
                pos = exp_b.eop ? 0 : pos + 1;
            end
        end
    end

    task automatic send_beat(input logic [11:0] len, input bit gaps);
        int tries;
        if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b1;
        in_real   = 16'($urandom);
        in_imag   = 16'($urandom);
        fftpts_in = len;
        last_re   = in_real;
        tries     = 0;
        while (!in_ready && tries < 1000) begin
            @(posedge clk);
            #1;
            tries++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n, input logic [11:0] len, input bit gaps);
        for (int i = 0; i < n; i++) send_beat(len, gaps);
    endtask

    task automatic drain();
        int t;
        in_valid = 1'b0;
        t = 0;
        while ((source_valid || q.size() != 0) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (source_valid || q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got valid=%0d expected 0", source_valid);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_async = 1'b1;
        in_valid  = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        fftpts_in = 12'd64;
        #1;
        chk("rst_valid", 64'(source_valid), 64'd0);
        chk("rst_fftpts", 64'(fftpts_out), 64'd64);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        repeat (3) @(posedge clk);
        #4;
        rst_async = 1'b0;
        #1;
        chk("in_ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("in_ready_after_edge", 64'(in_ready), 64'd1);

        // Two back-to-back 64-beat frames with ready always high
        drops     = 0;
        mon_drops = 1'b1;
        send_beat(12'd64, 1'b0);
        chk("latency_valid", 64'(source_valid), 64'd1);
        chk("latency_sop", 64'(source_sop), 64'd1);
        chk("latency_data", 64'(source_real), 64'(last_re));
        send_n(127, 12'd64, 1'b0);
        in_valid  = 1'b0;
        mon_drops = 1'b0;
        drain();
        chk("t1_frame_cnt", 64'(frame_cnt), 64'd2);
        chk("t1_fftpts_out", 64'(fftpts_out), 64'd64);
`ifdef CE_FRAME_GAP_EN
        chk("t1_in_ready_drops", 64'(drops), 64'd1);
`else
        chk("t1_in_ready_drops", 64'(drops), 64'd0);
`endif

        // Illegal length then a legal 256 frame
        err_beats = 0;
        send_n(64, 12'd100, 1'b0);
        send_n(256, 12'd256, 1'b0);
        drain();
        chk("t2_err_beats", 64'(err_beats), 64'd64);
        chk("t2_frame_cnt", 64'(frame_cnt), 64'd4);
        chk("t2_fftpts_out", 64'(fftpts_out), 64'd256);

        // Random backpressure and input gaps, 4 frames of 128
        rdy_rand = 1'b1;
        send_n(512, 12'd128, 1'b1);
        in_valid = 1'b0;
        rdy_rand = 1'b0;
        drain();
        chk("t3_frame_cnt", 64'(frame_cnt), 64'd8);

        // Length change mid-frame is ignored until the next frame
        send_n(10, 12'd64, 1'b0);
        send_n(54, 12'd2048, 1'b0);
        send_n(2048, 12'd2048, 1'b0);
        drain();
        chk("t4_frame_cnt", 64'(frame_cnt), 64'd10);
        chk("t4_fftpts_out", 64'(fftpts_out), 64'd2048);

        // Asynchronous reset in the middle of a frame
        send_n(30, 12'd64, 1'b0);
        in_valid = 1'b0;
        #3;
        rst_async = 1'b1;
        #1;
        chk("arst_valid", 64'(source_valid), 64'd0);
        chk("arst_sop", 64'(source_sop), 64'd0);
        chk("arst_real", 64'(source_real), 64'd0);
        chk("arst_fftpts", 64'(fftpts_out), 64'd64);
        chk("arst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #4;
        rst_async = 1'b0;
        @(posedge clk);
        #1;
        send_beat(12'd64, 1'b0);
        chk("post_rst_sop", 64'(source_sop), 64'd1);
        chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        send_n(63, 12'd64, 1'b0);
        drain();
        chk("post_rst_frames", 64'(frame_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
